// File: rtl/ped_crossing_ctrl.sv
// Demand-driven pedestrian crossing controller: minimum-green traffic phase, walk/flash
// pedestrian phases, request-pending lamp and flashing-amber night mode.
module ped_crossing_ctrl #(
    parameter int unsigned TIMER_SCALE = 16000000,
    parameter int unsigned GREEN_MIN_S = 10,
    parameter int unsigned YELLOW_S    = 3,
    parameter int unsigned ALL_RED_S   = 2,
    parameter int unsigned WALK_S      = 8,
    parameter int unsigned FLASH_S     = 4,
    parameter int unsigned CLEAR_S     = 2
) (
    input  logic pin3_clk_16mhz,
    input  logic pin2_reset,
    input  logic pin1_ped_button,
    input  logic pin10_night,
    output logic pin4_green,
    output logic pin5_yellow,
    output logic pin6_red,
    output logic pin7_ped_green,
    output logic pin8_ped_red,
    output logic pin9_wait
);

    localparam int unsigned PW = (TIMER_SCALE > 2) ? $clog2(TIMER_SCALE) : 1;
    localparam logic [PW-1:0] PresLast = PW'(TIMER_SCALE - 1);
    localparam logic [PW-1:0] PresHalf = PW'(TIMER_SCALE / 2 - 1);

    localparam logic [7:0] GreenMin   = 8'(GREEN_MIN_S);
    localparam logic [7:0] GreenLast  = 8'(GREEN_MIN_S - 1);
    localparam logic [7:0] YellowLast = 8'(YELLOW_S - 1);
    localparam logic [7:0] AllRedLast = 8'(ALL_RED_S - 1);
    localparam logic [7:0] WalkLast   = 8'(WALK_S - 1);
    localparam logic [7:0] FlashLast  = 8'(FLASH_S - 1);
    localparam logic [7:0] ClearLast  = 8'(CLEAR_S - 1);

    typedef enum logic [2:0] {
        StInit, StGreen, StYellow, StAllRed, StWalk, StFlash, StClear, StNight
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d;
    logic          blink_q, blink_d;
    logic          req_q, req_d;
    logic          btn_s1_q, btn_s2_q, btn_prev_q;
    logic          night_s1_q, night_s2_q;

    logic tick;
    logic min_done;
    logic btn_edge;
    logic entering;
    logic req_window;
    logic lamp_on;

    assign tick     = (presc_q == PresLast);
    assign btn_edge = btn_s2_q & ~btn_prev_q;
    // Minimum green counts the tick that completes the last second, matching timed phases.
    assign min_done = (sec_q >= GreenMin) || (tick && (sec_q == GreenLast));
    assign lamp_on  = ~blink_q;

    always_ff @(posedge pin3_clk_16mhz) begin
        if (pin2_reset) begin
            state_q    <= StInit;
            presc_q    <= '0;
            sec_q      <= '0;
            blink_q    <= 1'b0;
            req_q      <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            night_s1_q <= 1'b0;
            night_s2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            blink_q    <= blink_d;
            req_q      <= req_d;
            btn_s1_q   <= pin1_ped_button;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            night_s1_q <= pin10_night;
            night_s2_q <= night_s1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:   if (tick && (sec_q == AllRedLast)) state_d = StGreen;
            StGreen: begin
                if (min_done) begin
                    if (req_q) begin
                        state_d = StYellow;
                    end else if (night_s2_q) begin
                        state_d = StNight;
                    end
                end
            end
            StYellow: if (tick && (sec_q == YellowLast)) state_d = StAllRed;
            StAllRed: if (tick && (sec_q == AllRedLast)) state_d = StWalk;
            StWalk:   if (tick && (sec_q == WalkLast)) state_d = StFlash;
            StFlash:  if (tick && (sec_q == FlashLast)) state_d = StClear;
            StClear:  if (tick && (sec_q == ClearLast)) state_d = StGreen;
            StNight:  if (!night_s2_q) state_d = StInit;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        entering = (state_d != state_q);
        presc_d  = presc_q + PW'(1);
        sec_d    = sec_q;
        blink_d  = blink_q;
        if (tick) begin
            presc_d = '0;
            if (sec_q != 8'hFF) sec_d = sec_q + 8'd1;
        end
        if (tick || (presc_q == PresHalf)) blink_d = ~blink_q;
        if (entering) begin
            presc_d = '0;
            sec_d   = '0;
            blink_d = 1'b0;
        end
    end

    always_comb begin
        req_window = state_q inside {StGreen, StYellow, StAllRed, StFlash, StClear};
        req_d      = req_q;
        if ((state_q == StNight) || ((state_d == StWalk) && (state_q != StWalk))) begin
            req_d = 1'b0;
        end else if (btn_edge && req_window) begin
            req_d = 1'b1;
        end
    end

    always_comb begin
        pin4_green     = 1'b0;
        pin5_yellow    = 1'b0;
        pin6_red       = 1'b0;
        pin7_ped_green = 1'b0;
        pin8_ped_red   = 1'b0;
        pin9_wait      = req_q;
        case (state_q)
            StGreen: begin
                pin4_green   = 1'b1;
                pin8_ped_red = 1'b1;
            end
            StYellow: begin
                pin5_yellow  = 1'b1;
                pin8_ped_red = 1'b1;
            end
            StWalk: begin
                pin6_red       = 1'b1;
                pin7_ped_green = 1'b1;
            end
            StFlash: begin
                pin6_red       = 1'b1;
                pin7_ped_green = lamp_on;
            end
            StNight: begin
                pin5_yellow = lamp_on;
            end
            default: begin
                pin6_red     = 1'b1;
                pin8_ped_red = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed vector table, hand sequences for phase timing,
// and randomized stimulus against a clock-count reference model.
module tb_ped_crossing_ctrl;

    localparam int TS   = 4;
    localparam int GMIN = 3;
    localparam int YEL  = 2;
    localparam int AR   = 1;
    localparam int WLK  = 3;
    localparam int FLS  = 2;
    localparam int CLR  = 1;

    localparam logic [3:0] MInit = 4'd0, MGreen = 4'd1, MYellow = 4'd2, MAllRed = 4'd3;
    localparam logic [3:0] MWalk = 4'd4, MFlash = 4'd5, MClear = 4'd6, MNight = 4'd7;

    logic clk, rst, btn, night;
    logic g, y, r, pg, pr, w;
    wire logic [5:0] dut_l = {g, y, r, pg, pr, w};

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    ped_crossing_ctrl #(
        .TIMER_SCALE(TS), .GREEN_MIN_S(GMIN), .YELLOW_S(YEL), .ALL_RED_S(AR),
        .WALK_S(WLK), .FLASH_S(FLS), .CLEAR_S(CLR)
    ) dut (
        .pin3_clk_16mhz (clk),
        .pin2_reset     (rst),
        .pin1_ped_button(btn),
        .pin10_night    (night),
        .pin4_green     (g),
        .pin5_yellow    (y),
        .pin6_red       (r),
        .pin7_ped_green (pg),
        .pin8_ped_red   (pr),
        .pin9_wait      (w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phases timed in whole clocks since entry, inputs seen through delay lines.
    typedef struct packed {
        logic [3:0] ph;
        int         cnt;
        logic       req;
        logic       b1, b2, b3, n1, n2;
    } mdl_t;

    mdl_t mdl = '0;

    function automatic mdl_t mdl_step(input mdl_t m, input logic rs, input logic bi,
                                      input logic ni);
        mdl_t n;
        logic [3:0] nxt;
        logic press;
        n = m;
        if (rs) begin
            n = '0;
            return n;
        end
        press = m.b2 & ~m.b3;
        nxt   = m.ph;
        case (m.ph)
            MInit:   if (m.cnt == AR * TS - 1) nxt = MGreen;
            MGreen:  if (m.cnt >= GMIN * TS - 1) begin
                         if (m.req) nxt = MYellow;
                         else if (m.n2) nxt = MNight;
                     end
            MYellow: if (m.cnt == YEL * TS - 1) nxt = MAllRed;
            MAllRed: if (m.cnt == AR * TS - 1) nxt = MWalk;
            MWalk:   if (m.cnt == WLK * TS - 1) nxt = MFlash;
            MFlash:  if (m.cnt == FLS * TS - 1) nxt = MClear;
            MClear:  if (m.cnt == CLR * TS - 1) nxt = MGreen;
            MNight:  if (!m.n2) nxt = MInit;
            default: nxt = MInit;
        endcase
        if (m.ph == MNight || (nxt == MWalk && m.ph != MWalk)) n.req = 1'b0;
        else if (press && (m.ph inside {MGreen, MYellow, MAllRed, MFlash, MClear})) n.req = 1'b1;
        n.cnt = (nxt != m.ph) ? 0 : m.cnt + 1;
        n.ph  = nxt;
        n.b3  = m.b2;
        n.b2  = m.b1;
        n.b1  = bi;
        n.n2  = m.n1;
        n.n1  = ni;
        return n;
    endfunction

    function automatic logic [5:0] mdl_lamps(input mdl_t m);
        logic on;
        logic [5:0] l;
        on = (m.cnt % TS) < (TS / 2);
        case (m.ph)
            MGreen:  l = 6'b100010;
            MYellow: l = 6'b010010;
            MWalk:   l = 6'b001100;
            MFlash:  l = {3'b001, on, 2'b00};
            MNight:  l = {1'b0, on, 4'b0000};
            default: l = 6'b001010;
        endcase
        l[0] = m.req;
        return l;
    endfunction

    always @(posedge clk) mdl <= mdl_step(mdl, rst, btn, night);

    always @(negedge clk) begin
        if (chk_en) begin
            check("model", 32'(dut_l), 32'(mdl_lamps(mdl)));
            check("safety", 32'(!((g | y) & pg) && !(pg & pr) &&
                                (!(pg | pr) || $onehot({g, y, r}))), 32'd1);
        end
    end

    task automatic wait_for(input string name, input logic [5:0] v, input int limit);
        int n = 0;
        while (dut_l !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dut_l), 32'(v));
    endtask

    task automatic run_len(input logic [5:0] v, input int limit, output int n);
        n = 0;
        while (dut_l === v && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_btn();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    typedef struct {
        logic       rs;
        logic       bi;
        logic       ni;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;
        logic [19:0] pat;
        logic [7:0]  ypat;
        logic        other;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b001010};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'b001010};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 6'b001010};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 6'b001010};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'b100010};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 6'b100010};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'b100010};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 6'b100010};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 6'b100010};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'b100011};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 6'b100011};

        rst = 1'b1; btn = 1'b0; night = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rs; btn = tbl[i].bi; night = tbl[i].ni;
            @(negedge clk);
            check($sformatf("tbl%0d", i), 32'(dut_l), 32'(tbl[i].exp));
            chk_en = 1'b1;
        end

        // Full pedestrian cycle following the request from the table.
        run_len(6'b100011, 50, n); check("green_rest", 32'(n), 32'd6);
        run_len(6'b010011, 50, n); check("yellow_len", 32'(n), 32'd8);
        run_len(6'b001011, 50, n); check("allred_len", 32'(n), 32'd4);
        check("walk_entry", 32'(dut_l), 32'(6'b001100));
        pat = '0;
        for (int i = 0; i < 20; i++) begin
            pat = {pat[18:0], pg};
            @(negedge clk);
        end
        check("walk_flash_pat", 32'(pat), 32'(20'hFFFCC));
        run_len(6'b001010, 50, n); check("clear_len", 32'(n), 32'd4);
        check("green_after", 32'(dut_l), 32'(6'b100010));

        // Walk press ignored, flash press latched and served after one minimum green.
        pulse_btn();
        wait_for("to_walk", 6'b001100, 100);
        repeat (2) @(negedge clk);
        pulse_btn();
        repeat (4) @(negedge clk);
        check("walk_ignore", 32'(w), 32'd0);
        repeat (7) @(negedge clk);
        pulse_btn();
        repeat (2) @(negedge clk);
        check("flash_req", 32'(dut_l), 32'(6'b001101));
        wait_for("to_clear", 6'b001011, 20);
        run_len(6'b001011, 20, n); check("clear_wait_len", 32'(n), 32'd4);
        run_len(6'b100011, 50, n); check("green_min_len", 32'(n), 32'd12);
        check("amber_after_min", 32'(dut_l), 32'(6'b010011));
        wait_for("cycle_done", 6'b100010, 200);
        run_len(6'b100010, 40, n); check("green_hold", 32'(n), 32'd40);

        // Night mode: flashing amber, presses ignored, exit through INIT.
        night = 1'b1;
        wait_for("to_night", 6'b010000, 20);
        ypat = '0; other = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ypat  = {ypat[6:0], y};
            other = other | ((dut_l & 6'b101111) != 6'b0);
            if (i == 1) btn = 1'b1;
            if (i == 2) btn = 1'b0;
            @(negedge clk);
        end
        check("night_pat", 32'(ypat), 32'(8'b11001100));
        check("night_dark", 32'(other), 32'd0);
        night = 1'b0;
        wait_for("night_exit", 6'b001010, 20);
        run_len(6'b001010, 20, n); check("init_len", 32'(n), 32'd4);
        check("green_after_init", 32'(dut_l), 32'(6'b100010));

        // Request and night together: pedestrians first, then night after next min green.
        night = 1'b1;
        pulse_btn();
        wait_for("req_wins", 6'b010011, 40);
        wait_for("walk2", 6'b001100, 40);
        wait_for("clear2", 6'b001010, 40);
        wait_for("green2", 6'b100010, 20);
        run_len(6'b100010, 50, n); check("green2_len", 32'(n), 32'd12);
        check("night_after", 32'(dut_l), 32'(6'b010000));
        night = 1'b0;
        wait_for("green3", 6'b100010, 40);

        // Reset mid-walk.
        pulse_btn();
        wait_for("walk3", 6'b001100, 80);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_walk", 32'(dut_l), 32'(6'b001010));
        rst = 1'b0;

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            if ($urandom_range(0, 399) == 0) night = ~night;
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
